sel_word_packer: RTL
====================

Name: sel_word_packer

Overview:
- Assembles the 64-bit select/configuration word from individual host field writes; this is the inverse of the select-word field decoder.
- Holds a shadow word; on commit, atomically updates the active word and shifts it MSB-first into the downstream serial configuration chain, then pulses a load strobe.
- Sits between the host register interface and the TDC/FPGA configuration chain.

Parameters:
- CLKDIV, 4, clk cycles per ser_clk half-period (legal range 1..255).
- SHADOW_INIT, 64'h0, reset value of both the shadow word and the active word.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  field write strobe, one cycle.
- wr_addr  in  3  field select.
- wr_data  in  32  field value, LSB-aligned.
- commit  in  1  request copy shadow->active plus serial shift; level sampled each cycle.
- sel_word  out  64  active select word.
- ser_clk  out  1  serial chain clock.
- ser_data  out  1  serial chain data, MSB first.
- ser_load  out  1  chain latch strobe.
- ser_busy  out  1  shift/load sequence in progress.
- commit_done  out  1  one-cycle pulse at the end of the sequence.
- err_addr  out  1  one-cycle pulse on a write to an unmapped address.

Behaviour:
- Reset state (asynchronous): shadow=SHADOW_INIT, sel_word=SHADOW_INIT, FSM=IDLE, all other outputs 0.
- Field map, updated in the shadow word on the clk edge where wr_en=1:
  - addr0 -> bit[0] fpgasel (data[0])
  - addr1 -> [9:1] version (data[8:0])
  - addr2 -> [10] pencoder
  - addr3 -> [42:11] counters (data[31:0])
  - addr4 -> [44] dac1
  - addr5 -> [45] dac2
  - addr6 -> [48] status
  - addr7 -> no write; err_addr=1 on the next cycle.
- Bits 43, 46, 47 and 63:49 are always 0 in both shadow and active words. Unused wr_data bits are ignored.
- Shadow writes are accepted in every state, including while busy.
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, LOAD, DONE.
- IDLE: commit=1 at edge N causes, at N+1:
  - sel_word <= shadow, with any same-cycle write merged in (write-then-commit in the same cycle commits the new value);
  - shift register <= that value; bit index = 63; ser_busy=1; enter SHIFT_LO.
- SHIFT_LO: ser_clk=0 and ser_data=current bit, held for CLKDIV cycles, then go to SHIFT_HI.
- SHIFT_HI: ser_clk=1 for CLKDIV cycles; ser_data stable throughout. Then, if bit index=0, go to LOAD; otherwise decrement the index and go to SHIFT_LO.
- LOAD: ser_clk=0, ser_load=1 for CLKDIV cycles, then go to DONE.
- DONE: one cycle with commit_done=1 and ser_busy still 1; next cycle IDLE with ser_busy=0.
- Total time from ser_busy rise to commit_done: 128*CLKDIV + CLKDIV cycles. The commit_done pulse occupies the cycle after that.
- commit while ser_busy=1 is ignored: no queueing, sel_word unchanged.
- commit held high continuously re-triggers on the first IDLE cycle after DONE.
- ser_data=0 whenever the FSM is in IDLE.
- Reset asserted mid-sequence aborts immediately. Outputs go to reset values, and sel_word returns to SHADOW_INIT.

Optional Feature:
- Macro SEL_READBACK_EN.
- Defined:
  - Adds input ser_din (1 bit) and output rb_err (1 bit).
  - ser_din is sampled on each clk edge that ends a SHIFT_HI phase, which is the chain's rising-edge data. This yields 64 bits, MSB first.
  - The chain returns its previous contents, so the captured word is compared against the sel_word value that was active before this commit.
  - rb_err is registered and set at DONE if the words mismatch. It holds until the next commit starts; reset value 0.
- Undefined: no ser_din or rb_err ports, no capture logic.

Test Plan:
- Reset with SHADOW_INIT=0, CLKDIV=2 -> sel_word=0, ser_clk/ser_data/ser_load/ser_busy/commit_done=0.
- Writes addr0=1, addr1=9'h1A5, addr3=32'hDEADBEEF, addr6=1, then commit -> sel_word=64'h0001_06F5_6DF7_7B4B one cycle later. 64 ser_data bits captured on ser_clk rising edges equal that word. ser_load high 2 cycles; commit_done at 258 cycles after busy rise.
- Write addr7 with data 32'hFFFFFFFF -> err_addr one-cycle pulse; shadow and sel_word unchanged. Write addr2 data 32'hFFFFFFFE -> bit10=0.
- commit pulsed mid-shift, plus addr4 write mid-shift -> sequence unaffected. sel_word changes only after a second commit, which then shows bit44=1.
- rst_n low during bit 30 of a shift -> all outputs 0 asynchronously, sel_word=SHADOW_INIT. After release, the FSM is IDLE and a new commit completes normally.
- SEL_READBACK_EN, chain model returning the prior word 64'h0 -> rb_err=0. Corrupt one returned bit -> rb_err=1 after DONE, cleared at the next commit.

Source files
------------

// File: rtl/sel_word_packer.sv
// Builds the 64-bit select word from host field writes. On commit it updates the
// active word and shifts it MSB-first into the serial chain. SEL_READBACK_EN adds chain readback.
module sel_word_packer #(
   parameter int          CLKDIV      = 4,
   parameter logic [63:0] SHADOW_INIT = 64'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic [2:0]  wr_addr,
   input  logic [31:0] wr_data,
   input  logic        commit,
`ifdef SEL_READBACK_EN
   input  logic        ser_din,
   output logic        rb_err,
`endif
   output logic [63:0] sel_word,
   output logic        ser_clk,
   output logic        ser_data,
   output logic        ser_load,
   output logic        ser_busy,
   output logic        commit_done,
   output logic        err_addr
);

   // Only mapped field bits can ever be set: [42:0], 44, 45 and 48.
   localparam logic [63:0] FIELD_MASK = 64'h0001_37FF_FFFF_FFFF;
   localparam logic [63:0] INIT_WORD  = SHADOW_INIT & FIELD_MASK;
   localparam logic [7:0]  CNT_LAST   = 8'(CLKDIV - 1);

   typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LOAD, DONE} state_t;

   state_t      state_q, state_d;
   logic [63:0] shadow_q, shadow_d;
   logic [63:0] sel_q, sel_d;
   logic [63:0] sr_q, sr_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [5:0]  idx_q, idx_d;
   logic        ser_clk_q, ser_clk_d;
   logic        ser_data_q, ser_data_d;
   logic        ser_load_q, ser_load_d;
   logic        ser_busy_q, ser_busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        phase_end;
`ifdef SEL_READBACK_EN
   logic [63:0] cap_q, cap_d;
   logic [63:0] prev_q, prev_d;
   logic        rb_err_q, rb_err_d;
`endif

   assign phase_end = (cnt_q == CNT_LAST);

   always_comb begin
      shadow_d = shadow_q;
      err_d    = 1'b0;
      if (wr_en) begin
         case (wr_addr)
            3'd0:    shadow_d[0]     = wr_data[0];
            3'd1:    shadow_d[9:1]   = wr_data[8:0];
            3'd2:    shadow_d[10]    = wr_data[0];
            3'd3:    shadow_d[42:11] = wr_data;
            3'd4:    shadow_d[44]    = wr_data[0];
            3'd5:    shadow_d[45]    = wr_data[0];
            3'd6:    shadow_d[48]    = wr_data[0];
            default: err_d           = 1'b1;
         endcase
      end

      state_d = state_q;
      sel_d   = sel_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
`ifdef SEL_READBACK_EN
      cap_d    = cap_q;
      prev_d   = prev_q;
      rb_err_d = rb_err_q;
`endif
      case (state_q)
         IDLE: begin
            cnt_d = 8'd0;
            if (commit) begin
               // shadow_d already carries any write made in this same cycle
               sel_d   = shadow_d;
               sr_d    = shadow_d;
               idx_d   = 6'd63;
               state_d = SHIFT_LO;
`ifdef SEL_READBACK_EN
               prev_d   = sel_q;
               rb_err_d = 1'b0;
`endif
            end
         end
         SHIFT_LO: begin
            if (phase_end) begin
               cnt_d   = 8'd0;
               state_d = SHIFT_HI;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         SHIFT_HI: begin
            if (phase_end) begin
               cnt_d = 8'd0;
`ifdef SEL_READBACK_EN
               cap_d = {cap_q[62:0], ser_din};
`endif
               if (idx_q == 6'd0) begin
                  state_d = LOAD;
               end else begin
                  idx_d   = idx_q - 6'd1;
                  sr_d    = {sr_q[62:0], 1'b0};
                  state_d = SHIFT_LO;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         LOAD: begin
            if (phase_end) begin
               cnt_d   = 8'd0;
               state_d = DONE;
`ifdef SEL_READBACK_EN
               rb_err_d = (cap_q != prev_q);
`endif
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so they register alongside it.
      ser_clk_d  = (state_d == SHIFT_HI);
      ser_load_d = (state_d == LOAD);
      ser_busy_d = (state_d != IDLE);
      done_d     = (state_d == DONE);
      ser_data_d = ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) ? sr_d[63] : 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         shadow_q   <= INIT_WORD;
         sel_q      <= INIT_WORD;
         sr_q       <= 64'h0;
         cnt_q      <= 8'd0;
         idx_q      <= 6'd0;
         ser_clk_q  <= 1'b0;
         ser_data_q <= 1'b0;
         ser_load_q <= 1'b0;
         ser_busy_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
`ifdef SEL_READBACK_EN
         cap_q    <= 64'h0;
         prev_q   <= 64'h0;
         rb_err_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         shadow_q   <= shadow_d;
         sel_q      <= sel_d;
         sr_q       <= sr_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         ser_clk_q  <= ser_clk_d;
         ser_data_q <= ser_data_d;
         ser_load_q <= ser_load_d;
         ser_busy_q <= ser_busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
`ifdef SEL_READBACK_EN
         cap_q    <= cap_d;
         prev_q   <= prev_d;
         rb_err_q <= rb_err_d;
`endif
      end
   end

   assign sel_word    = sel_q;
   assign ser_clk     = ser_clk_q;
   assign ser_data    = ser_data_q;
   assign ser_load    = ser_load_q;
   assign ser_busy    = ser_busy_q;
   assign commit_done = done_q;
   assign err_addr    = err_q;
`ifdef SEL_READBACK_EN
   assign rb_err = rb_err_q;
`endif

endmodule
